// File: rtl/mem_port_arbiter.sv
// Single-port 16x8 unified RAM shared by instruction fetch, data access and
// a debug/program loader. One access per clock; loader has fixed priority,
// fetch/data alternate round-robin, and a requester that has waited
// MAX_WAIT cycles overrides the loader so the pipeline cannot starve.
module mem_port_arbiter #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_IF,
        SEL_DM,
        SEL_DBG
    } sel_e;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [2:0]        rvalid_q, rvalid_d;    // {dbg, dm, if}
    logic [WAIT_W-1:0] wait_if_q, wait_if_d;
    logic [WAIT_W-1:0] wait_dm_q, wait_dm_d;
    logic              rr_last_dm_q, rr_last_dm_d; // 1 = DM was granted last

    sel_e              sel;
    logic              if_aged, dm_aged;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_we;
    logic [DATA_W-1:0] acc_wdata;

    // Grant selection: aged IF/DM first, then loader, then round-robin IF/DM.
    always_comb begin
        sel     = SEL_NONE;
        if_aged = if_req && (wait_if_q == WAIT_MAX);
        dm_aged = dm_req && (wait_dm_q == WAIT_MAX);
        if (rst) begin
            sel = SEL_NONE;
        end else if (if_aged && dm_aged) begin
            sel = rr_last_dm_q ? SEL_IF : SEL_DM;
        end else if (if_aged) begin
            sel = SEL_IF;
        end else if (dm_aged) begin
            sel = SEL_DM;
        end else if (dbg_req) begin
            sel = SEL_DBG;
        end else if (if_req && dm_req) begin
            sel = rr_last_dm_q ? SEL_IF : SEL_DM;
        end else if (if_req) begin
            sel = SEL_IF;
        end else if (dm_req) begin
            sel = SEL_DM;
        end
    end

    assign if_gnt  = (sel == SEL_IF);
    assign dm_gnt  = (sel == SEL_DM);
    assign dbg_gnt = (sel == SEL_DBG);

    // Route the granted requester onto the single RAM port; fetch never writes.
    always_comb begin
        acc_addr  = '0;
        acc_we    = 1'b0;
        acc_wdata = '0;
        unique case (sel)
            SEL_IF: begin
                acc_addr = if_addr;
            end
            SEL_DM: begin
                acc_addr  = dm_addr;
                acc_we    = dm_we;
                acc_wdata = dm_wdata;
            end
            SEL_DBG: begin
                acc_addr  = dbg_addr;
                acc_we    = dbg_we;
                acc_wdata = dbg_wdata;
            end
            default: ;
        endcase
    end

    // Next-state for read data, read-valid pulses, wait counters and rr pointer.
    always_comb begin
        rdata_d      = rdata_q;
        rvalid_d     = 3'b000;
        wait_if_d    = '0;
        wait_dm_d    = '0;
        rr_last_dm_d = rr_last_dm_q;
        if (sel != SEL_NONE && !acc_we) begin
            rdata_d = mem_q[acc_addr];
            rvalid_d[0] = (sel == SEL_IF);
            rvalid_d[1] = (sel == SEL_DM);
            rvalid_d[2] = (sel == SEL_DBG);
        end
        if (if_req && sel != SEL_IF) begin
            wait_if_d = (wait_if_q == WAIT_MAX) ? WAIT_MAX : wait_if_q + 1'b1;
        end
        if (dm_req && sel != SEL_DM) begin
            wait_dm_d = (wait_dm_q == WAIT_MAX) ? WAIT_MAX : wait_dm_q + 1'b1;
        end
        if (sel == SEL_IF) begin
            rr_last_dm_d = 1'b0;
        end else if (sel == SEL_DM) begin
            rr_last_dm_d = 1'b1;
        end
    end

    // Arbiter and read-path state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q      <= '0;
            rvalid_q     <= 3'b000;
            wait_if_q    <= '0;
            wait_dm_q    <= '0;
            rr_last_dm_q <= 1'b1;
        end else begin
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            wait_if_q    <= wait_if_d;
            wait_dm_q    <= wait_dm_d;
            rr_last_dm_q <= rr_last_dm_d;
        end
    end

    // RAM words: cleared on reset, written when the granted access is a write.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else if (sel != SEL_NONE && acc_we && acc_addr == ADDR_W'(gi)) begin
                    mem_q[gi] <= acc_wdata;
                end
            end
        end
    endgenerate

    // A read completing into a reset cycle is not reported as valid.
    assign if_rvalid  = rvalid_q[0] & ~rst;
    assign dm_rvalid  = rvalid_q[1] & ~rst;
    assign dbg_rvalid = rvalid_q[2] & ~rst;
    assign rdata      = rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Owns the core's 16x8 unified program/data RAM and shares its single access port between three requesters: instruction fetch (IF stage), data access (MEM stage LOAD/STORE) and a debug/program loader.
- One RAM access per clock.
- Fixed-priority loader, round-robin fetch/data, and an aging override prevent pipeline starvation.
- The loader fills program memory after reset.

Parameters:
DATA_W, 8, RAM word width
ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
MAX_WAIT, 3, cycles an IF/DM requester may wait before its request overrides the loader

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
if_req  input  1  fetch read request
if_addr  input  ADDR_W  fetch address
if_gnt  output  1  fetch granted this cycle (combinational)
if_rvalid  output  1  rdata holds fetch result (registered)
dm_req  input  1  data access request
dm_we  input  1  1 = write, 0 = read
dm_addr  input  ADDR_W  data address
dm_wdata  input  DATA_W  write data
dm_gnt  output  1  data access granted (combinational)
dm_rvalid  output  1  rdata holds data-read result (registered)
dbg_req  input  1  loader request
dbg_we  input  1  1 = write, 0 = read
dbg_addr  input  ADDR_W  loader address
dbg_wdata  input  DATA_W  loader write data
dbg_gnt  output  1  loader granted (combinational)
dbg_rvalid  output  1  rdata holds loader-read result (registered)
rdata  output  DATA_W  shared read data, registered

Behaviour:
- Reset, synchronous while rst = 1:
  - all RAM words = 0
  - rdata = 0; all rvalid = 0
  - wait_if = wait_dm = 0
  - rr_last = DM, so IF wins the first IF/DM tie
  - gnt outputs = 0 while rst is high, regardless of req
- Reset mid-operation: a pending rvalid due next cycle is suppressed. A write granted in the same cycle rst is high is not performed.
- At most one gnt high per cycle. Grant selection, evaluated in order:
  1. Aged: a requesting IF/DM with wait counter == MAX_WAIT. If both are aged, grant the one != rr_last.
  2. dbg_req: grant loader.
  3. IF/DM: if both request, grant the one != rr_last; if one requests, grant it.
  4. Otherwise no grant.
- rr_last updates to the granted port whenever IF or DM is granted. It is unchanged on a loader grant or idle cycle.
- Wait counters (IF, DM independently):
  - +1 when req = 1 and gnt = 0, saturating at MAX_WAIT
  - cleared to 0 when granted or when req = 0
- Access timing:
  - address, we and wdata are sampled on the edge ending the grant cycle
  - write: RAM[addr] <= wdata at that edge; no rvalid
  - read: rdata <= RAM[addr] and the matching rvalid = 1 in the following cycle only (single-cycle pulse). rvalid = 0 in any cycle after a non-read or no grant.
  - rdata holds its last value when no read completes
- Request rule: a requester keeps req, addr, we and wdata stable until it sees gnt. Dropping req before gnt is legal and cancels the request, with no side effects.
- Back-to-back: a port holding req across consecutive cycles may be granted every cycle. Read-after-write to the same address in consecutive cycles returns the new data.
- Fetch port is read-only; no write path from IF.

Test Plan:
- Reset, then dbg writes 0x2E, 0x1F, 0x84 to addresses 0, 1, 2, then dbg reads 1:
  - dbg_gnt each cycle
  - dbg_rvalid one cycle after the read grant, with rdata = 0x1F
- if_req and dm_req (read, addr 14 = 0x01) held together from the cycle after reset:
  - grants alternate IF, DM, IF, DM
  - each rvalid follows its grant by exactly one cycle with the correct data
- dbg_req held continuously while if_req is held:
  - dbg granted for 3 cycles
  - if_gnt in the 4th cycle (aged at MAX_WAIT = 3)
  - dbg granted the next cycle; if_gnt again after 3 more waits
- DM write 0xAA to addr 13, then DM read addr 13 in the next cycle:
  - rdata = 0xAA with dm_rvalid high; no if_rvalid/dbg_rvalid
- rst asserted in the cycle after an IF read grant:
  - if_rvalid stays 0
  - all RAM words read back 0 via dbg after reset
- if_req dropped after 2 ungranted cycles, then reasserted:
  - wait counter restarted, so loader keeps priority for 3 further cycles before IF is granted
